tmr_vote_monitor: RTL and testbench

TMR_VOTE_MONITOR -- requirements
Module: tmr_vote_monitor

---
 rtl/tmr_vote_monitor.sv | 126 ++++++++++++
 tb/tb_tmr_vote_monitor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_vote_monitor.sv
// tmr_vote_monitor: lockstep vote monitor for three cores (master, slave1, slave2).
// Ports: clk, rst (async, active-high), clear (sync clear of all state);
//   per-core bus inputs instr_req/instr_addr, data_req/data_we/data_be/data_addr/data_wdata;
//   registered results valid, fault, faulty_core, isolated, err_cnt, state (00 TMR, 01 DMR, 10 FAILED), fatal.
module tmr_vote_monitor #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 8,
  parameter int ERR_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [2:0]               instr_req,
  input  logic [3*ADDR_W-1:0]      instr_addr,
  input  logic [2:0]               data_req,
  input  logic [2:0]               data_we,
  input  logic [3*(DATA_W/8)-1:0]  data_be,
  input  logic [3*ADDR_W-1:0]      data_addr,
  input  logic [3*DATA_W-1:0]      data_wdata,
  output logic                     valid,
  output logic                     fault,
  output logic [2:0]               faulty_core,
  output logic [2:0]               isolated,
  output logic [3*CNT_W-1:0]       err_cnt,
  output logic [1:0]               state,
  output logic                     fatal
);
  localparam int BE_W  = DATA_W / 8;
  localparam int SIG_W = 2 + 2 * ADDR_W + 1 + BE_W + DATA_W;
  localparam logic [1:0] TMR = 2'b00, DMR = 2'b01, FAILED = 2'b10;

  logic [SIG_W-1:0]   sig [3];
  logic               eq01, eq02, eq12, pair_eq, active;
  logic [2:0]         minority;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         state_q, state_d;
  logic [2:0]         isolated_q, isolated_d, faulty_core_q, faulty_core_d;
  logic [3*CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic               valid_q, valid_d, fault_q, fault_d, fatal_q, fatal_d;

  // Fields that are not qualified by their request are zeroed so stale bus values never cause mismatches.
  always_comb begin
    for (int k = 0; k < 3; k++)
      sig[k] = {instr_req[k],
                instr_req[k] ? instr_addr[k*ADDR_W +: ADDR_W] : {ADDR_W{1'b0}},
                data_req[k],
                data_req[k] ? {data_we[k], data_addr[k*ADDR_W +: ADDR_W], data_be[k*BE_W +: BE_W]}
                            : {(ADDR_W+BE_W+1){1'b0}},
                (data_req[k] & data_we[k]) ? data_wdata[k*DATA_W +: DATA_W] : {DATA_W{1'b0}}};
  end

  assign eq01    = sig[0] == sig[1];
  assign eq02    = sig[0] == sig[2];
  assign eq12    = sig[1] == sig[2];
  assign active  = |((instr_req | data_req) & ~isolated_q);
  // In DMR exactly one core is isolated; compare the remaining pair.
  assign pair_eq = isolated_q[0] ? eq12 : isolated_q[1] ? eq02 : eq01;
  // Equality is transitive, so a single agreeing pair identifies the lone dissenter.
  assign minority = {eq01 & ~eq02, eq02 & ~eq01, eq12 & ~eq01};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= TMR;
      isolated_q    <= '0;
      err_cnt_q     <= '0;
      valid_q       <= 1'b0;
      fault_q       <= 1'b0;
      faulty_core_q <= '0;
      fatal_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      isolated_q    <= isolated_d;
      err_cnt_q     <= err_cnt_d;
      valid_q       <= valid_d;
      fault_q       <= fault_d;
      faulty_core_q <= faulty_core_d;
      fatal_q       <= fatal_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    isolated_d    = isolated_q;
    err_cnt_d     = err_cnt_q;
    valid_d       = 1'b0;
    fault_d       = state_q == FAILED;
    faulty_core_d = '0;
    cnt           = '0;
    if (clear) begin
      state_d    = TMR;
      isolated_d = '0;
      err_cnt_d  = '0;
      fault_d    = 1'b0;
    end else if (active) begin
      valid_d = 1'b1;
      if (state_q == TMR && !(eq01 && eq02)) begin
        fault_d       = 1'b1;
        faulty_core_d = minority;
        state_d       = minority == '0 ? FAILED : TMR;
        for (int k = 0; k < 3; k++)
          if (minority[k]) begin
            cnt = err_cnt_q[k*CNT_W +: CNT_W];
            cnt = &cnt ? cnt : cnt + CNT_W'(1);
            err_cnt_d[k*CNT_W +: CNT_W] = cnt;
            if (cnt >= CNT_W'(ERR_LIMIT)) begin
              isolated_d[k] = 1'b1;
              state_d       = DMR;
            end
          end
      end else if (state_q == DMR && !pair_eq) begin
        fault_d = 1'b1;
        state_d = FAILED;
      end
    end
    fatal_d = state_d == FAILED;
  end

  assign valid       = valid_q;
  assign fault       = fault_q;
  assign faulty_core = faulty_core_q;
  assign isolated    = isolated_q;
  assign err_cnt     = err_cnt_q;
  assign state       = state_q;
  assign fatal       = fatal_q;
endmodule

// File: tb/tb_tmr_vote_monitor.sv
// tb_tmr_vote_monitor: directed bench with a vote-counting reference model for tmr_vote_monitor.
module tb_tmr_vote_monitor;
  logic        clk, rst, clear;
  logic [2:0]  instr_req, data_req, data_we;
  logic [95:0] instr_addr, data_addr, data_wdata;
  logic [11:0] data_be;
  logic        valid, fault, fatal;
  logic [2:0]  faulty_core, isolated;
  logic [23:0] err_cnt;
  logic [1:0]  state;
  int checks = 0, errors = 0;
  logic run = 1'b0;

  logic [1:0] m_state;
  logic [2:0] m_iso, m_fc;
  logic [7:0] m_cnt [3];
  logic       m_valid, m_fault;

  tmr_vote_monitor dut (
    .clk(clk), .rst(rst), .clear(clear),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .data_req(data_req), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .valid(valid), .fault(fault), .faulty_core(faulty_core), .isolated(isolated),
    .err_cnt(err_cnt), .state(state), .fatal(fatal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [102:0] sig(input int k);
    logic [31:0] ia, da, wd;
    ia = instr_req[k] ? instr_addr[k*32 +: 32] : 32'h0;
    da = data_addr[k*32 +: 32];
    wd = (data_req[k] && data_we[k]) ? data_wdata[k*32 +: 32] : 32'h0;
    return {instr_req[k], ia, data_req[k],
            data_req[k] ? {data_we[k], da, data_be[k*4 +: 4]} : 37'h0, wd};
  endfunction

  // Reference: count distinct signatures among the live cores and vote on them.
  always @(posedge clk or posedge rst) begin : model
    logic [102:0] s [3];
    int live [$];
    int st, distinct, minor, c [3];
    logic [2:0] iso, fc;
    logic v, f, act, uniq;
    if (rst) begin
      m_state <= 2'd0; m_iso <= 3'd0; m_fc <= 3'd0; m_valid <= 1'b0; m_fault <= 1'b0;
      for (int k = 0; k < 3; k++) m_cnt[k] <= 8'd0;
    end else begin
      st = int'(m_state); iso = m_iso; fc = 3'd0; v = 1'b0; f = (st == 2);
      for (int k = 0; k < 3; k++) c[k] = int'(m_cnt[k]);
      if (clear) begin
        st = 0; iso = 3'd0; f = 1'b0;
        for (int k = 0; k < 3; k++) c[k] = 0;
      end else begin
        live = {};
        act = 1'b0;
        for (int k = 0; k < 3; k++) begin
          s[k] = sig(k);
          if (!iso[k]) begin
            live.push_back(k);
            if (instr_req[k] || data_req[k]) act = 1'b1;
          end
        end
        if (act) begin
          v = 1'b1;
          distinct = 0;
          foreach (live[i]) begin
            uniq = 1'b1;
            for (int j = 0; j < i; j++) if (s[live[j]] == s[live[i]]) uniq = 1'b0;
            distinct += int'(uniq);
          end
          if (st != 2 && distinct > 1) begin
            f = 1'b1;
            if (live.size() == 3 && distinct == 2) begin
              minor = 0;
              for (int k = 0; k < 3; k++)
                if (s[k] != s[(k+1)%3] && s[k] != s[(k+2)%3]) minor = k;
              fc[minor] = 1'b1;
              if (c[minor] < 255) c[minor]++;
              if (c[minor] >= 4) begin
                iso[minor] = 1'b1;
                st = 1;
              end
            end else st = 2;
          end
        end
      end
      m_state <= 2'(st); m_iso <= iso; m_fc <= fc; m_valid <= v; m_fault <= f;
      for (int k = 0; k < 3; k++) m_cnt[k] <= 8'(c[k]);
    end
  end

  always @(negedge clk) if (run) begin
    chk("valid", {63'd0, valid}, {63'd0, m_valid});
    chk("fault", {63'd0, fault}, {63'd0, m_fault});
    chk("faulty_core", {61'd0, faulty_core}, {61'd0, m_fc});
    chk("isolated", {61'd0, isolated}, {61'd0, m_iso});
    chk("err_cnt", {40'd0, err_cnt}, {40'd0, m_cnt[2], m_cnt[1], m_cnt[0]});
    chk("state", {62'd0, state}, {62'd0, m_state});
    chk("fatal", {63'd0, fatal}, {63'd0, m_state == 2'd2});
  end

  task automatic set_core(input int k, input logic ir, input logic [31:0] ia, input logic dr,
                          input logic dw, input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd);
    instr_req[k] = ir; instr_addr[k*32 +: 32] = ia;
    data_req[k] = dr; data_we[k] = dw; data_be[k*4 +: 4] = be;
    data_addr[k*32 +: 32] = da; data_wdata[k*32 +: 32] = wd;
  endtask

  task automatic idle();
    for (int k = 0; k < 3; k++) set_core(k, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #2;
    run = 1'b1;
    chk("reset_state", {62'd0, state}, 64'd0);
    chk("reset_valid", {63'd0, valid}, 64'd0);
    chk("reset_err_cnt", {40'd0, err_cnt}, 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) set_core(k, 1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    chk("agree_valid", {63'd0, valid}, 64'd1);
    chk("agree_fault", {63'd0, fault}, 64'd0);
    chk("agree_state", {62'd0, state}, 64'd0);
    for (int k = 0; k < 3; k++)
      set_core(k, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h40, k == 2 ? 32'hDEAD : 32'hBEEF);
    step();
    chk("wdata_fault", {63'd0, fault}, 64'd1);
    chk("wdata_faulty_core", {61'd0, faulty_core}, 64'b100);
    chk("wdata_err_cnt2", {56'd0, err_cnt[23:16]}, 64'd1);
    idle();
    step();
    chk("idle_valid", {63'd0, valid}, 64'd0);
    chk("idle_fault", {63'd0, fault}, 64'd0);
    for (int k = 0; k < 3; k++) set_core(k, 1'b0, 32'h0, 1'b1, k != 0, 4'hF, 32'h40, 32'h5);
    step();
    chk("we_faulty_core", {61'd0, faulty_core}, 64'b001);
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 3; k++)
        set_core(k, 1'b1, k == 1 ? 32'h300 + 32'(n) : 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      step();
      if (n == 2) begin
        chk("below_limit_isolated", {61'd0, isolated}, 64'd0);
        chk("below_limit_err_cnt1", {56'd0, err_cnt[15:8]}, 64'd3);
      end
    end
    chk("limit_err_cnt1", {56'd0, err_cnt[15:8]}, 64'd4);
    chk("limit_isolated", {61'd0, isolated}, 64'b010);
    chk("limit_state", {62'd0, state}, 64'd1);
    set_core(0, 1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_core(1, 1'b1, 32'hBAD, 1'b1, 1'b1, 4'h3, 32'h77, 32'h99);
    set_core(2, 1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    chk("dmr_garbage_valid", {63'd0, valid}, 64'd1);
    chk("dmr_garbage_fault", {63'd0, fault}, 64'd0);
    idle();
    set_core(1, 1'b1, 32'hBAD, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    chk("isolated_only_valid", {63'd0, valid}, 64'd0);
    set_core(0, 1'b1, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_core(1, 1'b1, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_core(2, 1'b1, 32'h204, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    chk("dmr_fault", {63'd0, fault}, 64'd1);
    chk("dmr_faulty_core", {61'd0, faulty_core}, 64'd0);
    chk("dmr_state", {62'd0, state}, 64'd2);
    chk("dmr_fatal", {63'd0, fatal}, 64'd1);
    set_core(2, 1'b1, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    chk("failed_sticky_fault", {63'd0, fault}, 64'd1);
    chk("failed_sticky_valid", {63'd0, valid}, 64'd1);
    idle();
    step();
    chk("failed_idle_valid", {63'd0, valid}, 64'd0);
    chk("failed_idle_fault", {63'd0, fault}, 64'd1);
    clear = 1'b1;
    for (int k = 0; k < 3; k++) set_core(k, 1'b1, 32'h10 * 32'(k), 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    chk("clear_state", {62'd0, state}, 64'd0);
    chk("clear_err_cnt", {40'd0, err_cnt}, 64'd0);
    chk("clear_fault", {63'd0, fault}, 64'd0);
    chk("clear_isolated", {61'd0, isolated}, 64'd0);
    clear = 1'b0;
    step();
    chk("distinct_state", {62'd0, state}, 64'd2);
    chk("distinct_faulty_core", {61'd0, faulty_core}, 64'd0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear2_state", {62'd0, state}, 64'd0);
    chk("clear2_valid", {63'd0, valid}, 64'd0);
    for (int k = 0; k < 3; k++)
      set_core(k, 1'b0, 32'h0, 1'b0, 1'b1, 4'hF, 32'h10 * 32'(k), 32'h1234 + 32'(k));
    step();
    chk("noreq_valid", {63'd0, valid}, 64'd0);
    chk("noreq_fault", {63'd0, fault}, 64'd0);
    for (int k = 0; k < 3; k++)
      set_core(k, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h1234 + 32'(k));
    step();
    chk("read_mask_valid", {63'd0, valid}, 64'd1);
    chk("read_mask_fault", {63'd0, fault}, 64'd0);
    for (int k = 0; k < 3; k++)
      set_core(k, 1'b1, k == 0 ? 32'h4 : 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    chk("pre_rst_fault", {63'd0, fault}, 64'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_fault", {63'd0, fault}, 64'd0);
    chk("async_rst_valid", {63'd0, valid}, 64'd0);
    chk("async_rst_faulty_core", {61'd0, faulty_core}, 64'd0);
    chk("async_rst_err_cnt", {40'd0, err_cnt}, 64'd0);
    idle();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_idle_valid", {63'd0, valid}, 64'd0);
    for (int k = 0; k < 3; k++) set_core(k, 1'b1, 32'h500, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    chk("post_rst_valid", {63'd0, valid}, 64'd1);
    chk("post_rst_fault", {63'd0, fault}, 64'd0);
    idle();
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
